// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential binary-to-BCD converter (double dabble).
//
// One conversion takes W iterations, one per clock, after the start edge.
//
// Handshake: st is sampled on every rising clk edge. It is accepted only in
// IDLE or DONE, and ignored while busy=1. A start request is not queued.
// Once accepted, bin is captured and busy rises. Exactly W edges later, bcd
// is updated and done pulses for one cycle. bcd holds its value between
// completions.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   st         start request
//   bin[W-1:0] unsigned binary input, sampled only on the accepted start edge
//   busy       high while a conversion is in progress (SHIFT state)
//   done       one-cycle pulse when bcd is updated
//   bcd[4D-1:0] packed BCD result; digit 0 is in bits [3:0]
//   dbg_state  current FSM state (0=IDLE, 1=SHIFT, 2=DONE), for observation
module bin2bcd_seq #(
  parameter int W = 32,
  parameter int D = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           st,
  input  logic [W-1:0]   bin,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd,
  output logic [1:0]     dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The counter must reach W without wrapping.
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state;
  logic [W-1:0]   sreg;
  logic [4*D-1:0] acc;
  logic [4*D-1:0] acc_adj;
  logic [4*D-1:0] acc_next;
  logic [CW-1:0]  cnt;

  // One double-dabble step.
  // First add 3 to every digit >= 5.
  // Then shift the next binary MSB into the accumulator.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < D; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
    acc_next = {acc_adj[4*D-2:0], sreg[W-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      acc   <= '0;
      cnt   <= '0;
      bcd   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (st) begin
            sreg  <= bin;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          acc  <= acc_next;
          sreg <= {sreg[W-2:0], 1'b0};
          cnt  <= cnt + 1'b1;
          // The last iteration publishes its own result on this same edge.
          // Intermediate accumulator values therefore never reach bcd.
          if (cnt == LAST) begin
            bcd   <= acc_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq -- directed testbench for bin2bcd_seq (W=32, D=10).
// Inputs are driven 1 ns after a rising edge, and outputs are sampled there.
module tb_bin2bcd_seq;

  localparam int W = 32;
  localparam int D = 10;

  logic           clk;
  logic           rst;
  logic           st;
  logic [W-1:0]   bin;
  logic           busy;
  logic           done;
  logic [4*D-1:0] bcd;
  logic [1:0]     dbg_state;

  int total;
  int bad;

  bin2bcd_seq #(.W(W), .D(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .st        (st),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start request.
  // On return, the start edge (k) has passed and the bench is at sample c=0.
  task automatic start(input logic [W-1:0] v);
    st  = 1'b1;
    bin = v;
    step();
    st  = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 40'h0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b bcd=%h st=%0d exp 0 0 0 0",
               busy, done, bcd, dbg_state);
    end
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int done_at;
    done_at = -1;
    start(32'd23);
    for (int c = 0; c <= W + 1; c++) begin
      // Change bin during SHIFT: the captured value must be used.
      bin = $urandom;
      total++;
      if (busy !== (c < W)) begin
        bad++;
        $display("FAIL basic_busy c=%0d: got %b exp %b", c, busy, (c < W));
      end
      if (done === 1'b1 && done_at < 0) done_at = c;
      if (c == W) begin
        total++;
        if (bcd !== 40'h0000000023) begin
          bad++;
          $display("FAIL basic_bcd: got %h exp 0000000023", bcd);
        end
      end
      step();
    end
    total++;
    if (done_at != W) begin
      bad++;
      $display("FAIL basic_latency: got %0d exp %0d", done_at, W);
    end
  endtask

  task automatic test_ignore_busy();
    int ndone;
    ndone = 0;
    start(32'd450);
    for (int c = 0; c <= W + 2; c++) begin
      if (c == 5) begin
        st  = 1'b1;
        bin = 32'd999;
      end
      if (c == 6) st = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        total++;
        if (c != W) begin
          bad++;
          $display("FAIL ignore_done_time: got %0d exp %0d", c, W);
        end
      end
      if (c == W + 2) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL ignore_restart: busy got %b exp 0", busy);
        end
      end
      step();
    end
    total++;
    if (ndone != 1) begin
      bad++;
      $display("FAIL ignore_done_count: got %0d exp 1", ndone);
    end
    total++;
    if (bcd !== 40'h0000000450) begin
      bad++;
      $display("FAIL ignore_bcd: got %h exp 0000000450", bcd);
    end
  endtask

  task automatic test_zero();
    start(32'd0);
    for (int c = 0; c <= W; c++) begin
      total++;
      if (c < W && bcd !== 40'h0000000450) begin
        bad++;
        $display("FAIL zero_hold c=%0d: got %h exp 0000000450", c, bcd);
      end else if (c == W && (bcd !== 40'h0 || done !== 1'b1)) begin
        bad++;
        $display("FAIL zero_result: got %h done=%b exp 0000000000 done=1", bcd, done);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic exp_pulse;
    st  = 1'b1;
    bin = 32'd78;
    step();
    for (int c = 0; c <= 2*W + 2; c++) begin
      exp_pulse = (c == W) || (c == 2*W + 1);
      if (c == 3) bin = 32'd0;
      total++;
      if (done !== exp_pulse) begin
        bad++;
        $display("FAIL b2b_done c=%0d: got %b exp %b", c, done, exp_pulse);
      end
      total++;
      if (busy !== ((c <= 2*W) && !exp_pulse)) begin
        bad++;
        $display("FAIL b2b_busy c=%0d: got %b exp %b", c, busy,
                 ((c <= 2*W) && !exp_pulse));
      end
      if (c == W) begin
        total++;
        if (bcd !== 40'h0000000078) begin
          bad++;
          $display("FAIL b2b_first: got %h exp 0000000078", bcd);
        end
      end
      if (c == 2*W + 1) begin
        total++;
        if (bcd !== 40'h0) begin
          bad++;
          $display("FAIL b2b_second: got %h exp 0000000000", bcd);
        end
        st = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_full_scale();
    start(32'hFFFF_FFFF);
    for (int c = 0; c < W; c++) step();
    total++;
    if (done !== 1'b1 || bcd !== 40'h4294967295) begin
      bad++;
      $display("FAIL full_scale: got %h done=%b exp 4294967295 done=1", bcd, done);
    end
    step();
  endtask

  task automatic test_mid_reset();
    int done_at;
    done_at = -1;
    start(32'd23);
    // Stop at sample c=10, after the edge that completes iteration 10.
    for (int c = 0; c < 10; c++) step();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 40'h0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL mid_reset: busy=%b done=%b bcd=%h st=%0d exp 0 0 0 0",
               busy, done, bcd, dbg_state);
    end
    step();
    rst = 1'b0;
    // Start on the first edge after reset is released.
    st  = 1'b1;
    bin = 32'd2024;
    step();
    st = 1'b0;
    for (int c = 0; c <= W; c++) begin
      if (c == 0) begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL post_reset_start: busy got %b exp 1", busy);
        end
      end
      if (done === 1'b1 && done_at < 0) done_at = c;
      step();
    end
    total++;
    if (done_at != W || bcd !== 40'h0000002024) begin
      bad++;
      $display("FAIL post_reset_conv: done_at=%0d bcd=%h exp %0d 0000002024",
               done_at, bcd, W);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    st    = 1'b0;
    bin   = '0;
    test_reset();
    test_basic();
    test_ignore_busy();
    test_zero();
    test_back_to_back();
    test_full_scale();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
